dac_frame_arbiter: RTL and testbench

- Shares the single 14-bit DAC output between two sample sources, e.g. the test-signal generator and the user data path.
- Emits fixed-length frames: GUARD_LEN guard samples at IDLE_CODE, then PAYLOAD_LEN samples pulled from the granted source. The default 16 + 256 = 272-cycle frame matches the existing test-signal framing.
- Arbitrates round-robin only at frame boundaries.
- Issues a one-cycle frame_start pulse that sources use to restart their generators (e.g. LFSR reset).

---
 rtl/dac_frame_arbiter.sv | 139 +++++++++++++
 tb/tb_dac_frame_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_arbiter.sv
// dac_frame_arbiter: shares one DAC between two sample sources using fixed-length
// frames (guard samples at IDLE_CODE, then payload from the granted source).
// Arbitration is round-robin and happens only at frame boundaries.
// Optional build macro DAC_HOLD_ON_UNDERRUN_EN: when defined, an underrunning
// payload cycle repeats the previous dac_out value instead of driving IDLE_CODE.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no frame; dac_out at IDLE_CODE, waiting for any request
// S_GUARD   | GUARD_LEN cycles of IDLE_CODE; frame_start on the first
// S_PAYLOAD | PAYLOAD_LEN cycles pulling samples from the granted source
module dac_frame_arbiter #(
  parameter int              DW          = 14,
  parameter int              GUARD_LEN   = 16,
  parameter int              PAYLOAD_LEN = 256,
  parameter logic [DW-1:0]   IDLE_CODE   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  output logic [1:0]    grant,
  output logic          frame_start,
  output logic          busy,
  output logic [DW-1:0] dac_out,
  output logic          underrun,
  input  logic          underrun_clr
);

  localparam int MAX_LEN = (GUARD_LEN > PAYLOAD_LEN) ? GUARD_LEN : PAYLOAD_LEN;
  localparam int CW      = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_LEN - 1);
  localparam logic [CW-1:0] PAYLOAD_LAST = CW'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GUARD   = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_src;   // 1 when source 1 held the most recent grant
  logic          any_req;
  logic          pick1;
  logic          src_valid;
  logic [DW-1:0] src_data;

  // Source 1 wins when it is the only requester, or on a tie when source 0 went last.
  assign any_req   = req0 | req1;
  assign pick1     = req1 & (~req0 | ~last_src);

  assign s0_ready  = (state == S_PAYLOAD) & grant[0];
  assign s1_ready  = (state == S_PAYLOAD) & grant[1];
  assign src_valid = grant[1] ? s1_valid : s0_valid;
  assign src_data  = grant[1] ? s1_data  : s0_data;

  // Frame sequencer with registered DAC code, grant, strobes and sticky underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_src    <= 1'b1;
      grant       <= 2'b00;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      dac_out     <= IDLE_CODE;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      // A same-cycle underrun in S_PAYLOAD overrides this clear.
      if (underrun_clr) underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          dac_out <= IDLE_CODE;
          if (any_req) begin
            state       <= S_GUARD;
            cnt         <= '0;
            grant       <= pick1 ? 2'b10 : 2'b01;
            last_src    <= pick1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_GUARD: begin
          dac_out <= IDLE_CODE;
          if (cnt == GUARD_LAST) begin
            state <= S_PAYLOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PAYLOAD: begin
          if (src_valid) begin
            dac_out <= src_data;
          end else begin
`ifdef DAC_HOLD_ON_UNDERRUN_EN
            dac_out <= dac_out;
`else
            dac_out <= IDLE_CODE;
`endif
            underrun <= 1'b1;
          end
          if (cnt == PAYLOAD_LAST) begin
            cnt <= '0;
            if (any_req) begin
              state       <= S_GUARD;
              grant       <= pick1 ? 2'b10 : 2'b01;
              last_src    <= pick1;
              frame_start <= 1'b1;
              busy        <= 1'b1;
            end else begin
              state <= S_IDLE;
              grant <= 2'b00;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          grant   <= 2'b00;
          busy    <= 1'b0;
          dac_out <= IDLE_CODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_arbiter.sv
// tb_dac_frame_arbiter: scoreboard bench for dac_frame_arbiter, default framing
// plus a GUARD_LEN=1/PAYLOAD_LEN=1 instance. Honours DAC_HOLD_ON_UNDERRUN_EN.
module tb_dac_frame_arbiter;
  localparam int DW = 14;
  localparam int GL = 16;
  localparam int PL = 256;
  localparam logic [DW-1:0] IDLE = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req0, req1, s0_valid, s1_valid, underrun_clr;
  logic [DW-1:0] s0_data, s1_data, dac_out;
  logic          s0_ready, s1_ready, frame_start, busy, underrun;
  logic [1:0]    grant;

  logic          sh_rst, sh_req0, sh_req1, sh_s0_valid, sh_s1_valid, sh_underrun_clr;
  logic [DW-1:0] sh_s0_data, sh_s1_data, sh_dac_out;
  logic          sh_s0_ready, sh_s1_ready, sh_frame_start, sh_busy, sh_underrun;
  logic [1:0]    sh_grant;

  dac_frame_arbiter #(.DW(DW), .GUARD_LEN(GL), .PAYLOAD_LEN(PL), .IDLE_CODE(IDLE)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .grant(grant), .frame_start(frame_start), .busy(busy), .dac_out(dac_out),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  dac_frame_arbiter #(.DW(DW), .GUARD_LEN(1), .PAYLOAD_LEN(1), .IDLE_CODE(IDLE)) dut_sh (
    .clk(clk), .rst(sh_rst), .req0(sh_req0), .req1(sh_req1),
    .s0_data(sh_s0_data), .s0_valid(sh_s0_valid), .s0_ready(sh_s0_ready),
    .s1_data(sh_s1_data), .s1_valid(sh_s1_valid), .s1_ready(sh_s1_ready),
    .grant(sh_grant), .frame_start(sh_frame_start), .busy(sh_busy), .dac_out(sh_dac_out),
    .underrun(sh_underrun), .underrun_clr(sh_underrun_clr)
  );

  int            vec = 0;
  int            errs = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_push;
  bit            ur_exp, ur_next;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; compare dac_out with the scoreboard and underrun with the flag model.
  task automatic tick();
    @(posedge clk);
    #1;
    ur_exp = ur_next;
    if (exp_q.size() != 0) check("dac_out", 32'(dac_out), 32'(exp_q.pop_front()));
    check("underrun", 32'(underrun), 32'(ur_exp));
  endtask

  task automatic step(input logic [DW-1:0] v, input bit set);
    exp_q.push_back(v);
    last_push = v;
    ur_next   = set | (ur_exp & ~underrun_clr);
    tick();
  endtask

  task automatic step_rst();
    exp_q.delete();
    exp_q.push_back(IDLE);
    last_push = IDLE;
    ur_next   = 1'b0;
    tick();
  endtask

  task automatic idle_cycle();
    check("idle_grant", 32'(grant), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_frame_start", 32'(frame_start), 0);
    check("idle_ready", 32'({s1_ready, s0_ready}), 0);
    underrun_clr = 1'b0;
    step(IDLE, 1'b0);
  endtask

  // Called in the cycle where frame_start is expected; g is the expected one-hot grant.
  // Negative indices disable the underrun / clear / request-drop / reset events.
  task automatic frame(input int g, input int under_at, input int clr_at,
                       input int drop_at, input int rst_at);
    logic [DW-1:0] d;
    bit            v;
    check("frame_start", 32'(frame_start), 1);
    for (int i = 0; i < GL; i++) begin
      if (i > 0) check("frame_start_guard", 32'(frame_start), 0);
      check("grant_guard", 32'(grant), 32'(g));
      check("busy_guard", 32'(busy), 1);
      check("ready_guard", 32'({s1_ready, s0_ready}), 0);
      if (i == drop_at) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      underrun_clr = 1'b0;
      s0_valid = 1'($urandom);
      s1_valid = 1'($urandom);
      s0_data  = DW'($urandom);
      s1_data  = DW'($urandom);
      step(IDLE, 1'b0);
    end
    for (int i = 0; i < PL; i++) begin
      d = DW'($urandom);
      v = (i != under_at);
      s0_data  = (g == 1) ? d : DW'($urandom);
      s0_valid = (g == 1) ? v : 1'($urandom);
      s1_data  = (g == 2) ? d : DW'($urandom);
      s1_valid = (g == 2) ? v : 1'($urandom);
      underrun_clr = (i == clr_at);
      check("frame_start_payload", 32'(frame_start), 0);
      check("grant_payload", 32'(grant), 32'(g));
      check("busy_payload", 32'(busy), 1);
      check("ready_payload", 32'({s1_ready, s0_ready}), 32'(g));
      if (i == rst_at) begin
        rst = 1'b1;
        step_rst();
        return;
      end
      if (v) begin
        step(d, 1'b0);
      end else begin
`ifdef DAC_HOLD_ON_UNDERRUN_EN
        step(last_push, 1'b1);
`else
        step(IDLE, 1'b1);
`endif
      end
    end
    underrun_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            g;
    logic [DW-1:0] prev;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; underrun_clr = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    sh_rst = 1'b1; sh_req0 = 1'b0; sh_req1 = 1'b0; sh_underrun_clr = 1'b0;
    sh_s0_valid = 1'b0; sh_s1_valid = 1'b0; sh_s0_data = '0; sh_s1_data = '0;
    ur_exp = 1'b0; ur_next = 1'b0; last_push = IDLE;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dac_out", 32'(dac_out), 32'(IDLE));
    check("rst_grant", 32'(grant), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_ready", 32'({s1_ready, s0_ready}), 0);

    // single source, back-to-back frames
    rst = 1'b0;
    req0 = 1'b1;
    idle_cycle();
    frame(1, -1, -1, -1, -1);
    req1 = 1'b1;
    // underrun at payload sample 5 with a simultaneous clear: set must win
    frame(1, 5, 5, -1, -1);
    // contention: source 1 next, clear alone during its payload
    frame(2, -1, 20, -1, -1);
    // contention back to source 0; both requests drop at guard cycle 3
    frame(1, -1, -1, 3, -1);
    repeat (3) idle_cycle();

    // mid-frame reset at payload sample 100 after an underrun
    req0 = 1'b1;
    idle_cycle();
    frame(1, 5, -1, -1, 100);
    check("mrst_grant", 32'(grant), 0);
    check("mrst_ready", 32'({s1_ready, s0_ready}), 0);
    check("mrst_busy", 32'(busy), 0);
    rst = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    idle_cycle();
    // pointer was reset, so source 0 wins the tie again
    frame(1, -1, -1, 3, -1);
    repeat (2) idle_cycle();

    // short frames: GUARD_LEN=1, PAYLOAD_LEN=1
    sh_rst = 1'b0;
    sh_req0 = 1'b1;
    sh_req1 = 1'b1;
    sh_s0_valid = 1'b1;
    sh_s1_valid = 1'b1;
    prev = IDLE;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      g = (k % 2 == 0) ? 1 : 2;
      check("sh_frame_start", 32'(sh_frame_start), 1);
      check("sh_grant_guard", 32'(sh_grant), 32'(g));
      check("sh_busy", 32'(sh_busy), 1);
      check("sh_ready_guard", 32'({sh_s1_ready, sh_s0_ready}), 0);
      if (k > 0) check("sh_dac_out", 32'(sh_dac_out), 32'(prev));
      @(posedge clk);
      #1;
      sh_s0_data = DW'($urandom);
      sh_s1_data = DW'($urandom);
      prev = (g == 1) ? sh_s0_data : sh_s1_data;
      check("sh_frame_start_payload", 32'(sh_frame_start), 0);
      check("sh_grant_payload", 32'(sh_grant), 32'(g));
      check("sh_ready_payload", 32'({sh_s1_ready, sh_s0_ready}), 32'(g));
      check("sh_dac_idle", 32'(sh_dac_out), 32'(IDLE));
      @(posedge clk);
      #1;
    end
    check("sh_underrun", 32'(sh_underrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
